// File: rtl/aes_loader_pkg.sv
// aes_loader_pkg: shared state encoding and word/block geometry for the AES block loader
package aes_loader_pkg;
    typedef enum logic [1:0] {FILL, ISSUE, GAP} state_t;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W = 32;
endpackage

// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if: 32-bit valid/ready word stream with a key/data group tag
interface aes_block_loader_if;
    import aes_loader_pkg::*;
    logic [WORD_W-1:0] s_word;
    logic s_is_key;
    logic s_valid;
    logic s_ready;
    modport master (output s_word, s_is_key, s_valid, input s_ready);
    modport slave (input s_word, s_is_key, s_valid, output s_ready);
endinterface

// File: rtl/aes_word_collector.sv
// aes_word_collector: shifts four 32-bit words into a 128-bit group, first word landing in the top slot
module aes_word_collector
    import aes_loader_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    input  logic [WORD_W-1:0] word,
    output logic [WORDS_PER_BLOCK*WORD_W-1:0] data,
    output logic [2:0] count
);
    logic [WORDS_PER_BLOCK*WORD_W-1:0] sr;
    // data already includes the word being loaded this cycle, so a completing word can be captured directly
    assign data = load ? {sr[(WORDS_PER_BLOCK-1)*WORD_W-1:0], word} : sr;
    always_ff @(posedge clk)
        if (rst) begin
            sr <= '0;
            count <= '0;
        end else begin
            if (load) sr <= data;
            count <= clr ? 3'd0 : load ? count + 3'd1 : count;
        end
endmodule

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles key/data groups for AES_top and holds them until done (AES_LOADER_TIMEOUT_EN adds ISSUE abort)
module aes_block_loader
    import aes_loader_pkg::*;
#(
    parameter int MIN_GAP = 2,
    parameter int CNT_W = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic AES_clk,
    input  logic AES_rst,
    aes_block_loader_if.slave stream,
    output logic AES_en,
    output logic [127:0] AES_data_in,
    output logic [127:0] AES_key_in,
    input  logic AES_data_out_valid,
    output logic busy,
    output logic [CNT_W-1:0] blk_count
`ifdef AES_LOADER_TIMEOUT_EN
    ,
    output logic timeout_err
`endif
);
    localparam int BW = WORDS_PER_BLOCK * WORD_W;
    state_t state, next;
    logic [BW-1:0] k_data, d_data;
    logic [2:0] k_cnt, d_cnt;
    logic key_full, k_acc, d_acc, k_last, issue, tmo, done;
    logic [15:0] gap;

    assign k_acc = stream.s_valid & stream.s_ready & stream.s_is_key;
    assign d_acc = stream.s_valid & stream.s_ready & ~stream.s_is_key;
    assign k_last = k_acc && k_cnt == 3'(WORDS_PER_BLOCK - 1);
    assign issue = state == FILL && d_cnt == 3'(WORDS_PER_BLOCK) && key_full;
    assign done = state == ISSUE && (AES_data_out_valid || tmo);

    aes_word_collector u_key (
        .clk(AES_clk), .rst(AES_rst), .load(k_acc), .clr(k_last),
        .word(stream.s_word), .data(k_data), .count(k_cnt)
    );
    aes_word_collector u_data (
        .clk(AES_clk), .rst(AES_rst), .load(d_acc), .clr(issue),
        .word(stream.s_word), .data(d_data), .count(d_cnt)
    );

    always_ff @(posedge AES_clk)
        state <= AES_rst ? FILL : next;

    // the FILL cycle itself counts as one low cycle, so GAP leaves one cycle early
    always_comb
        next = state == FILL ? (issue ? ISSUE : FILL)
             : state == ISSUE ? (done ? GAP : ISSUE)
             : (gap < 16'd2 ? FILL : GAP);

    always_comb begin
        busy = state != FILL;
        stream.s_ready = stream.s_is_key ? state == FILL : d_cnt < 3'(WORDS_PER_BLOCK);
    end

    always_ff @(posedge AES_clk)
        if (AES_rst) begin
            AES_en <= 1'b0;
            AES_data_in <= '0;
            AES_key_in <= '0;
            blk_count <= '0;
            key_full <= 1'b0;
            gap <= '0;
        end else begin
            AES_en <= next == ISSUE;
            if (issue) AES_data_in <= d_data;
            if (k_last) AES_key_in <= k_data;
            key_full <= k_last | (key_full & ~k_acc);
            if (state == ISSUE && AES_data_out_valid) blk_count <= blk_count + CNT_W'(1);
            gap <= done ? 16'(MIN_GAP - 1) : (state == GAP && gap != 16'd0) ? gap - 16'd1 : gap;
        end

`ifdef AES_LOADER_TIMEOUT_EN
    logic [15:0] tcnt;
    assign tmo = tcnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge AES_clk)
        if (AES_rst) begin
            tcnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt <= state == ISSUE ? tcnt + 16'd1 : 16'd0;
            if (state == ISSUE && tmo && !AES_data_out_valid) timeout_err <= 1'b1;
        end
`else
    assign tmo = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: table vectors, directed corner sequences and a randomized scoreboard for aes_block_loader
module tb_aes_block_loader;
    import aes_loader_pkg::*;
    typedef struct {
        bit load_key;
        logic [0:3][31:0] kw;
        logic [0:3][31:0] dw;
        logic [127:0] exp_key;
        logic [127:0] exp_data;
        int hold;
    } vec_t;
    logic clk = 1'b0;
    logic rst, en, dov, busy;
    logic [127:0] din, kin;
    logic [15:0] blk;
`ifdef AES_LOADER_TIMEOUT_EN
    logic terr;
`endif
    int vecs = 0, errs = 0, exp_blk = 0;
    vec_t tbl [3];
    logic [0:3][31:0] w3, b2, nk, d5, d6, d8, nk2, rk, rd;
    logic [127:0] fips_key, mkey;
    logic bad;
    int c;

    aes_block_loader_if bus ();
    aes_block_loader dut (
        .AES_clk(clk), .AES_rst(rst), .stream(bus), .AES_en(en),
        .AES_data_in(din), .AES_key_in(kin), .AES_data_out_valid(dov),
        .busy(busy), .blk_count(blk)
`ifdef AES_LOADER_TIMEOUT_EN
        , .timeout_err(terr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic k);
        int n = 0;
        logic ok;
        bus.s_word = w;
        bus.s_is_key = k;
        bus.s_valid = 1'b1;
        do begin
            #1 ok = bus.s_ready;
            step();
            n++;
        end while (!ok && n < 300);
        bus.s_valid = 1'b0;
        if (!ok) begin
            vecs++;
            errs++;
            $display("FAIL send: word %h not accepted, ready %b required 1", w, ok);
        end
    endtask

    task automatic send_group(input logic [0:3][31:0] w, input logic k);
        for (int j = 0; j < 4; j++) send(w[j], k);
    endtask

    task automatic wait_en();
        int n = 0;
        while (en !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic pulse();
        dov = 1'b1;
        step();
        dov = 1'b0;
        exp_blk++;
    endtask

    initial begin
        rst = 1'b1;
        dov = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_is_key = 1'b0;
        bus.s_word = '0;
        tbl[0] = '{1'b1, {32'haa2bdb40, 32'hbff6a5e8, 32'hcaa9ba3e, 32'hbc1e2acc},
                   {32'h000000b7, 32'h0, 32'h0, 32'h0},
                   128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                   128'h000000b7_00000000_00000000_00000000, 50};
        tbl[1] = '{1'b1, {32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f},
                   {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff},
                   128'h00010203_04050607_08090a0b_0c0d0e0f,
                   128'h00112233_44556677_8899aabb_ccddeeff, 3};
        tbl[2] = '{1'b0, {32'h0, 32'h0, 32'h0, 32'h0},
                   {32'hffffffff, 32'h12345678, 32'h0, 32'h80000000},
                   128'h00010203_04050607_08090a0b_0c0d0e0f,
                   128'hffffffff_12345678_00000000_80000000, 0};
        fips_key = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        w3 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        b2 = {32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681};
        nk = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98};
        d5 = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        d6 = {32'h99999999, 32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc};
        d8 = {32'h0badf00d, 32'hcafebabe, 32'h13579bdf, 32'h2468ace0};
        nk2 = {32'hf0f0f0f0, 32'h0f0f0f0f, 32'h3c3c3c3c, 32'hc3c3c3c3};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_en", en, 0);
        chk("rst_data", din, 0);
        chk("rst_key", kin, 0);
        chk("rst_blk", blk, 0);
        chk("rst_busy", busy, 0);
        bus.s_is_key = 1'b0;
        #1 chk("rst_ready_data", bus.s_ready, 1);
        bus.s_is_key = 1'b1;
        #1 chk("rst_ready_key", bus.s_ready, 1);
        bus.s_is_key = 1'b0;
        step();

        for (int i = 0; i < 3; i++) begin
            if (tbl[i].load_key) send_group(tbl[i].kw, 1'b1);
            send_group(tbl[i].dw, 1'b0);
            chk("tbl_latency_en_low", en, 0);
            step();
            chk("tbl_en", en, 1);
            chk("tbl_busy", busy, 1);
            chk("tbl_key", kin, tbl[i].exp_key);
            chk("tbl_data", din, tbl[i].exp_data);
            bad = 1'b0;
            repeat (tbl[i].hold) begin
                step();
                if (en !== 1'b1 || din !== tbl[i].exp_data || kin !== tbl[i].exp_key) bad = 1'b1;
            end
            chk("tbl_hold_stable", bad, 0);
            pulse();
            chk("tbl_en_fall", en, 0);
            chk("tbl_blk", blk, 16'(exp_blk));
            step();
            step();
            chk("tbl_gap_en", en, 0);
        end

        dov = 1'b1;
        step();
        dov = 1'b0;
        chk("fill_valid_ignored_blk", blk, 16'(exp_blk));
        chk("fill_valid_ignored_en", en, 0);

        send_group(w3, 1'b0);
        wait_en();
        chk("b2b_first_en", en, 1);
        chk("b2b_first_data", din, {w3[0], w3[1], w3[2], w3[3]});
        send_group(b2, 1'b0);
        bus.s_is_key = 1'b0;
        #1 chk("b2b_ready_drop", bus.s_ready, 0);
        chk("b2b_still_issue", en, 1);
        chk("b2b_data_frozen", din, {w3[0], w3[1], w3[2], w3[3]});
        pulse();
        chk("b2b_gap1", en, 0);
        chk("b2b_blk1", blk, 16'(exp_blk));
        step();
        chk("b2b_gap2", en, 0);
        step();
        chk("b2b_reissue", en, 1);
        chk("b2b_data2", din, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
        pulse();
        chk("b2b_blk2", blk, 16'(exp_blk));
        step();
        step();

        send_group(d5, 1'b0);
        wait_en();
        chk("kiss_en", en, 1);
        bus.s_word = nk[0];
        bus.s_is_key = 1'b1;
        bus.s_valid = 1'b1;
        #1 chk("kiss_ready_issue", bus.s_ready, 0);
        step();
        chk("kiss_key_hold", kin, fips_key);
        pulse();
        #1 chk("kiss_ready_gap", bus.s_ready, 0);
        step();
        #1 chk("kiss_ready_fill", bus.s_ready, 1);
        step();
        bus.s_valid = 1'b0;
        chk("kiss_key_partial", kin, fips_key);
        for (int j = 1; j < 4; j++) send(nk[j], 1'b1);
        send_group(d6, 1'b0);
        wait_en();
        chk("kiss_new_key", kin, 128'hdeadbeef_01234567_89abcdef_fedcba98);
        chk("kiss_new_data", din, {d6[0], d6[1], d6[2], d6[3]});
        pulse();
        chk("kiss_blk", blk, 16'(exp_blk));
        step();
        step();

        send_group(d5, 1'b0);
        wait_en();
        send(d6[0], 1'b0);
        send(d6[1], 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_blk = 0;
        chk("mrst_en", en, 0);
        chk("mrst_data", din, 0);
        chk("mrst_key", kin, 0);
        chk("mrst_blk", blk, 0);
        chk("mrst_busy", busy, 0);
        send_group(d8, 1'b0);
        bad = 1'b0;
        repeat (6) begin
            step();
            if (en !== 1'b0) bad = 1'b1;
        end
        chk("mrst_no_issue_without_key", bad, 0);
        send_group(nk2, 1'b1);
        wait_en();
        chk("mrst_key2", kin, 128'hf0f0f0f0_0f0f0f0f_3c3c3c3c_c3c3c3c3);
        chk("mrst_data2", din, 128'h0badf00d_cafebabe_13579bdf_2468ace0);
        pulse();
        chk("mrst_blk2", blk, 16'(exp_blk));
        step();
        step();

        mkey = '0;
        for (int it = 0; it < 30; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0) begin
                for (int j = 0; j < 4; j++) rk[j] = $urandom;
                for (int j = 0; j < 4; j++) begin
                    repeat ($urandom_range(0, 2)) begin
                        dov = 1'($urandom_range(0, 1));
                        step();
                    end
                    dov = 1'b0;
                    send(rk[j], 1'b1);
                end
                mkey = {rk[0], rk[1], rk[2], rk[3]};
            end
            for (int j = 0; j < 4; j++) rd[j] = $urandom;
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    dov = 1'($urandom_range(0, 1));
                    step();
                end
                dov = 1'b0;
                send(rd[j], 1'b0);
            end
            chk("rnd_blk_before", blk, 16'(exp_blk));
            wait_en();
            chk("rnd_en", en, 1);
            chk("rnd_key", kin, mkey);
            chk("rnd_data", din, {rd[0], rd[1], rd[2], rd[3]});
            repeat ($urandom_range(0, 8)) step();
            pulse();
            chk("rnd_en_fall", en, 0);
            chk("rnd_blk", blk, 16'(exp_blk));
            step();
            step();
        end

`ifdef AES_LOADER_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_blk = 0;
        chk("to_rst_err", terr, 0);
        send_group(tbl[0].kw, 1'b1);
        send_group(tbl[0].dw, 1'b0);
        wait_en();
        chk("to_en", en, 1);
        c = 0;
        while (en === 1'b1 && c < 200) begin
            step();
            c++;
        end
        chk("to_issue_cycles", c, 64);
        chk("to_err", terr, 1);
        chk("to_blk", blk, 0);
        repeat (4) step();
        chk("to_err_sticky", terr, 1);
        chk("to_en_low", en, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
